// File: rtl/alu_pkg.sv
// Shared constants for the ALU: data width, opcode encodings and compare-flag bit positions.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd4;
    localparam logic [OP_W-1:0] OP_MUL = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;
    localparam logic [OP_W-1:0] OP_DIV = 4'd7;

    localparam int CMP_LT_BIT = 0;
    localparam int CMP_EQ_BIT = 1;
    localparam int CMP_GT_BIT = 2;

    localparam logic [DATA_W-1:0] DIV_BY_ZERO_RESULT = 8'hFF;

endpackage

// File: rtl/alu.sv
// Single-cycle 8-bit ALU: a combinational next-result selector feeding one result register
// that updates only when io_execute is high.
module alu
    import alu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_execute,
    input  logic [OP_W-1:0]   io_operation,
    input  logic              io_compare,
    input  logic [DATA_W-1:0] io_rs,
    input  logic [DATA_W-1:0] io_rt,
    output logic [DATA_W-1:0] io_output
);

    logic [DATA_W-1:0]   result_d;
    logic [DATA_W-1:0]   result_q;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   cmp_flags;

    // A zero divisor saturates to all-ones instead of relying on simulator/tool semantics.
    function automatic logic [DATA_W-1:0] div_sat(input logic [DATA_W-1:0] num,
                                                  input logic [DATA_W-1:0] den);
        logic [DATA_W-1:0] q;
        if (den == '0) begin
            q = DIV_BY_ZERO_RESULT;
        end else begin
            q = num / den;
        end
        return q;
    endfunction

    assign product = {{DATA_W{1'b0}}, io_rs} * {{DATA_W{1'b0}}, io_rt};

    always_comb begin
        cmp_flags             = '0;
        cmp_flags[CMP_GT_BIT] = (io_rs > io_rt);
        cmp_flags[CMP_EQ_BIT] = (io_rs == io_rt);
        cmp_flags[CMP_LT_BIT] = (io_rs < io_rt);
    end

    always_comb begin
        result_d = '0;
        if (io_compare) begin
            result_d = cmp_flags;
        end else begin
            case (io_operation)
                OP_ADD:  result_d = io_rs + io_rt;
                OP_MUL:  result_d = product[DATA_W-1:0];
                OP_SUB:  result_d = io_rs - io_rt;
                OP_DIV:  result_d = div_sat(io_rs, io_rt);
                default: result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (io_execute) begin
            result_q <= result_d;
        end
    end

    assign io_output = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: each vector carries a hand-computed expected result.
module tb_alu;

    logic       clock;
    logic       reset;
    logic       io_execute;
    logic [3:0] io_operation;
    logic       io_compare;
    logic [7:0] io_rs;
    logic [7:0] io_rt;
    logic [7:0] io_output;

    int n_checks = 0;
    int n_errors = 0;

    alu dut (
        .clock        (clock),
        .reset        (reset),
        .io_execute   (io_execute),
        .io_operation (io_operation),
        .io_compare   (io_compare),
        .io_rs        (io_rs),
        .io_rt        (io_rt),
        .io_output    (io_output)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Present a vector on the falling edge, capture on the next rising edge, sample 1 time unit later.
    task automatic exec(input logic cmp, input logic [3:0] op,
                        input logic [7:0] rs, input logic [7:0] rt);
        @(negedge clock);
        io_compare   = cmp;
        io_operation = op;
        io_rs        = rs;
        io_rt        = rt;
        io_execute   = 1'b1;
        @(posedge clock);
        #1;
        io_execute   = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic cmp, input logic [3:0] op,
                           input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] exp);
        exec(cmp, op, rs, rt);
        check(tag, io_output, exp);
    endtask

    initial begin
        reset        = 1'b0;
        io_execute   = 1'b0;
        io_operation = 4'd0;
        io_compare   = 1'b0;
        io_rs        = 8'd0;
        io_rt        = 8'd0;

        // Execute requested while held in reset must be ignored.
        #2;
        io_execute   = 1'b1;
        io_operation = 4'd4;
        io_rs        = 8'd10;
        io_rt        = 8'd3;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", io_output, 8'h00);
        io_execute = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        run_vec("cmp_gt",       1'b1, 4'd0, 8'd10,  8'd3,  8'h04);
        run_vec("cmp_lt",       1'b1, 4'd0, 8'd3,   8'd10, 8'h01);
        run_vec("cmp_eq",       1'b1, 4'd0, 8'd5,   8'd5,  8'h02);
        run_vec("cmp_gt_max",   1'b1, 4'd0, 8'd255, 8'd2,  8'h04);
        run_vec("cmp_prec_mul", 1'b1, 4'd5, 8'd3,   8'd10, 8'h01);
        run_vec("add",          1'b0, 4'd4, 8'd10,  8'd3,  8'h0D);
        run_vec("add_wrap",     1'b0, 4'd4, 8'd255, 8'd2,  8'h01);
        run_vec("mul",          1'b0, 4'd5, 8'd10,  8'd3,  8'h1E);
        run_vec("mul_trunc",    1'b0, 4'd5, 8'd255, 8'd2,  8'hFE);
        run_vec("mul_sq",       1'b0, 4'd5, 8'd5,   8'd5,  8'h19);
        run_vec("sub_wrap",     1'b0, 4'd6, 8'd3,   8'd10, 8'hF9);
        run_vec("sub",          1'b0, 4'd6, 8'd10,  8'd3,  8'h07);
        run_vec("div",          1'b0, 4'd7, 8'd10,  8'd3,  8'h03);
        run_vec("div_big",      1'b0, 4'd7, 8'd255, 8'd2,  8'h7F);
        run_vec("div_zero",     1'b0, 4'd7, 8'd10,  8'd0,  8'hFF);
        run_vec("op0",          1'b0, 4'd0, 8'd10,  8'd3,  8'h00);
        run_vec("add_again",    1'b0, 4'd4, 8'd1,   8'd1,  8'h02);
        run_vec("op8",          1'b0, 4'd8, 8'd10,  8'd3,  8'h00);
        run_vec("op3",          1'b0, 4'd3, 8'd1,   8'd1,  8'h00);
        run_vec("op15",         1'b0, 4'hF, 8'd10,  8'd3,  8'h00);

        // Hold: operands and opcode change without execute.
        run_vec("hold_setup",   1'b0, 4'd4, 8'd10,  8'd3,  8'h0D);
        @(negedge clock);
        io_rs        = 8'd255;
        io_operation = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("hold_%0d", i), io_output, 8'h0D);
        end

        // Asynchronous reset between edges.
        run_vec("rst_setup",    1'b0, 4'd5, 8'd10,  8'd3,  8'h1E);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", io_output, 8'h00);
        io_compare   = 1'b0;
        io_operation = 4'd4;
        io_rs        = 8'd20;
        io_rt        = 8'd22;
        io_execute   = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ignore_exec", io_output, 8'h00);
        io_execute = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release_idle", io_output, 8'h00);
        run_vec("rst_after_exec", 1'b0, 4'd4, 8'd20, 8'd22, 8'h2A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = in reset, 1 = run).
REQ-003 io_execute  input  1  result-capture enable for the current cycle.
REQ-004 io_operation  input  4  arithmetic opcode, used only when io_compare=0.
REQ-005 io_compare  input  1  1 = comparison mode, overrides io_operation.
REQ-006 io_rs  input  8  first operand, unsigned.
REQ-007 io_rt  input  8  second operand, unsigned.
REQ-008 io_output  output  8  registered result.

Function
REQ-009 io_output SHALL be driven directly from an 8-bit result register, with no combinational path from inputs to output.
REQ-010 On a rising clock edge with io_execute=1, the register SHALL load the next result; 1-cycle latency, visible after that edge.
REQ-011 With io_execute=0, the register SHALL hold its value indefinitely.
REQ-012 Compare mode (io_compare=1) SHALL load {5'b0, gt, eq, lt}: bit2 = rs>rt, bit1 = rs==rt, bit0 = rs<rt, unsigned; exactly one flag set.
REQ-013 io_compare=1 SHALL take precedence over any io_operation value.
REQ-014 Opcode 4'd4 ADD SHALL load (rs+rt) mod 256; carry discarded.
REQ-015 Opcode 4'd5 MUL SHALL load the low 8 bits of the 16-bit product rs*rt.
REQ-016 Opcode 4'd6 SUB SHALL load (rs-rt) mod 256 (two's-complement wrap).
REQ-017 Opcode 4'd7 DIV SHALL load floor(rs/rt) when rt!=0, and 8'hFF when rt==0.
REQ-018 DIV SHALL be single-cycle combinational, with no multi-cycle handshake.
REQ-019 All other opcodes (0-3, 8-15) with io_compare=0 SHALL load 8'h00.
REQ-020 Operand changes without io_execute=1 SHALL NOT affect io_output.

Reset
REQ-021 Asserting reset low SHALL clear the result register to 8'h00 immediately, independent of clock.
REQ-022 While reset is low, io_execute SHALL be ignored and io_output SHALL stay 8'h00.
REQ-023 Reset asserted mid-operation SHALL discard any pending result; the first capture occurs on the first rising edge with reset high and io_execute=1.

Structure
REQ-024 Opcode constants (ADD=4, MUL=5, SUB=6, DIV=7) and compare-flag bit positions SHALL reside in a shared package alu_pkg.
REQ-025 The block SHALL be one flat module: one combinational next-result selector plus one 8-bit register, with no sub-module.

Verification
REQ-026 Compare: rs=10,rt=3 -> 8'h04; rs=3,rt=10 -> 8'h01; rs=5,rt=5 -> 8'h02; rs=255,rt=2 -> 8'h04.
REQ-027 ADD: 10+3 -> 8'h0D; 255+2 -> 8'h01 (wrap). MUL: 10*3 -> 8'h1E; 255*2 -> 8'hFE; 5*5 -> 8'h19.
REQ-028 SUB: 3-10 -> 8'hF9; DIV: 10/3 -> 8'h03; 10/0 -> 8'hFF; opcode 4'd0 with compare=0 -> 8'h00.
REQ-029 Hold: after ADD 10+3 (8'h0D), drop io_execute and change rs=255 and op=MUL -> io_output stays 8'h0D for 3 cycles.
REQ-030 Reset: with io_output=8'h1E, drive reset low between edges -> io_output is 8'h00 before the next edge; after release, the next execute updates normally.
REQ-031 Precedence: io_compare=1 with op=4'd5, rs=3, rt=10 -> 8'h01, not the product.
